// File: rtl/ctrl_hazard.sv
// rtl/ctrl_hazard.sv - pipeline stall/bubble/flush control with multi-cycle watchdog
module ctrl_hazard #(
  parameter int MC_TIMEOUT = 64,
  parameter int FLUSH_CYC  = 1,
  parameter int CNT_W      = 7
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_ren_i,
  input  logic        id_rs2_ren_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_load_i,
  input  logic        ex_mc_start_i,
  input  logic        ex_mc_done_i,
  input  logic        ex_jump_i,
  input  logic [31:0] ex_jump_addr_i,
  output logic [4:0]  stall_o,
  output logic        bubble_o,
  output logic        ex_bubble_o,
  output logic        flush_o,
  output logic        jump_o,
  output logic [31:0] jump_addr_o,
  output logic        mc_timeout_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    FLUSH   = 2'd2,
    UNUSED  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] MC_LAST = CNT_W'(MC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FL_LAST = CNT_W'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [31:0]       jump_addr_q;

  logic [4:0]        stall_c;
  logic              bubble_c, ex_bubble_c, flush_c, jump_c, timeout_c;
  logic              lu;

  // Saturating increment so a stuck counter can never wrap back into range
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  // Load-use hazard: decode needs a register the load in execute has not produced yet
  assign lu = ex_load_i && (ex_rd_addr_i != 5'd0) &&
              ((id_rs1_ren_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
               (id_rs2_ren_i && (id_rs2_addr_i == ex_rd_addr_i)));

  // Next-state and same-cycle control decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_c     = 5'b00000;
    bubble_c    = 1'b0;
    ex_bubble_c = 1'b0;
    flush_c     = 1'b0;
    jump_c      = 1'b0;
    timeout_c   = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_jump_i) begin
          jump_c  = 1'b1;
          flush_c = 1'b1;
          cnt_d   = CNT_ONE;
          state_d = (FLUSH_CYC > 1) ? FLUSH : RUN;
        end else if (ex_mc_start_i) begin
          stall_c     = 5'b00111;
          ex_bubble_c = 1'b1;
          cnt_d       = CNT_ONE;
          state_d     = MC_WAIT;
        end else if (lu) begin
          stall_c  = 5'b00011;
          bubble_c = 1'b1;
        end
      end
      MC_WAIT: begin
        if (ex_mc_done_i) begin
          cnt_d   = '0;
          state_d = RUN;
        end else if (cnt_q == MC_LAST) begin
          timeout_c = 1'b1;
          cnt_d     = '0;
          state_d   = RUN;
        end else begin
          stall_c     = 5'b00111;
          ex_bubble_c = 1'b1;
          cnt_d       = cnt_inc;
        end
      end
      FLUSH: begin
        flush_c = 1'b1;
        if (cnt_q == FL_LAST) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = RUN;
      end
    endcase
  end

  // State, counter and held jump target
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      jump_addr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (jump_c) begin
        jump_addr_q <= ex_jump_addr_i;
      end
    end
  end

  // Outputs are forced low while reset is asserted, independent of the inputs
  assign stall_o      = rstn ? 5'b00000 : stall_c;
  assign bubble_o     = !rstn && bubble_c;
  assign ex_bubble_o  = !rstn && ex_bubble_c;
  assign flush_o      = !rstn && flush_c;
  assign jump_o       = !rstn && jump_c;
  assign mc_timeout_o = !rstn && timeout_c;
  assign jump_addr_o  = rstn ? 32'h0 : (jump_c ? ex_jump_addr_i : jump_addr_q);
  assign state_o      = state_q;

endmodule

// File: tb/tb_ctrl_hazard.sv
// tb/tb_ctrl_hazard.sv - directed self-checking bench for ctrl_hazard
module tb_ctrl_hazard;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        rs1_ren, rs2_ren, load;
  logic        mc_start_a, mc_done_a, mc_start_b, mc_done_b;
  logic        jump;
  logic [31:0] jump_addr;

  logic [4:0]  a_stall, b_stall;
  logic        a_bubble, b_bubble, a_exb, b_exb, a_flush, b_flush;
  logic        a_jump, b_jump, a_to, b_to;
  logic [31:0] a_jaddr, b_jaddr;
  logic [1:0]  a_state, b_state;

  int checks;
  int failures;
  logic saw_to;

  // Short timeout and multi-cycle flush
  ctrl_hazard #(.MC_TIMEOUT(8), .FLUSH_CYC(3), .CNT_W(7)) u_dut_a (
    .clk(clk), .rstn(rst),
    .id_rs1_addr_i(rs1_addr), .id_rs2_addr_i(rs2_addr),
    .id_rs1_ren_i(rs1_ren), .id_rs2_ren_i(rs2_ren),
    .ex_rd_addr_i(rd_addr), .ex_load_i(load),
    .ex_mc_start_i(mc_start_a), .ex_mc_done_i(mc_done_a),
    .ex_jump_i(jump), .ex_jump_addr_i(jump_addr),
    .stall_o(a_stall), .bubble_o(a_bubble), .ex_bubble_o(a_exb),
    .flush_o(a_flush), .jump_o(a_jump), .jump_addr_o(a_jaddr),
    .mc_timeout_o(a_to), .state_o(a_state)
  );

  // Default parameters: long timeout, single-cycle flush
  ctrl_hazard u_dut_b (
    .clk(clk), .rstn(rst),
    .id_rs1_addr_i(rs1_addr), .id_rs2_addr_i(rs2_addr),
    .id_rs1_ren_i(rs1_ren), .id_rs2_ren_i(rs2_ren),
    .ex_rd_addr_i(rd_addr), .ex_load_i(load),
    .ex_mc_start_i(mc_start_b), .ex_mc_done_i(mc_done_b),
    .ex_jump_i(jump), .ex_jump_addr_i(jump_addr),
    .stall_o(b_stall), .bubble_o(b_bubble), .ex_bubble_o(b_exb),
    .flush_o(b_flush), .jump_o(b_jump), .jump_addr_o(b_jaddr),
    .mc_timeout_o(b_to), .state_o(b_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lu();
    load = 1'b0; rd_addr = 5'd0;
    rs1_ren = 1'b0; rs2_ren = 1'b0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
  endtask

  task automatic set_lu();
    load = 1'b1; rd_addr = 5'd5;
    rs2_ren = 1'b1; rs2_addr = 5'd5;
    rs1_ren = 1'b1; rs1_addr = 5'd3;
  endtask

  initial begin
    checks = 0; failures = 0; saw_to = 1'b0;
    rst = 1'b1;
    mc_start_a = 0; mc_done_a = 0; mc_start_b = 0; mc_done_b = 0;
    jump = 0; jump_addr = 32'h0;
    set_lu();

    // Outputs stay low in reset even with a hazard on the inputs
    @(negedge clk);
    check("rst_state", a_state, 0);
    check("rst_stall", a_stall, 0);
    check("rst_bubble", a_bubble, 0);
    clear_lu();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rel_state", a_state, 0);
    check("rel_stall", a_stall, 0);
    check("rel_flush", a_flush, 0);
    check("rel_jaddr", a_jaddr, 32'h0);
    check("rel_to", a_to, 0);

    // Load-use via rs2
    step();
    set_lu();
    @(negedge clk);
    check("lu_rs2_stall", a_stall, 5'b00011);
    check("lu_rs2_bubble", a_bubble, 1);
    check("lu_rs2_exb", a_exb, 0);
    check("lu_rs2_state", a_state, 0);
    // x0 never hazards
    rd_addr = 5'd0; rs2_addr = 5'd0; rs1_addr = 5'd0;
    #1;
    check("lu_x0_stall", a_stall, 0);
    check("lu_x0_bubble", a_bubble, 0);
    // rs1 match with read enable
    rd_addr = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd1;
    #1;
    check("lu_rs1_stall", a_stall, 5'b00011);
    // rs1 match without read enable
    rs1_ren = 1'b0;
    #1;
    check("lu_noren_stall", a_stall, 0);
    // Not a load
    rs1_ren = 1'b1; load = 1'b0;
    #1;
    check("lu_noload_stall", a_stall, 0);
    clear_lu();

    // Watchdog: 7 stall cycles then a one-cycle timeout
    step();
    mc_start_a = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("to_stall", a_stall, (i < 7) ? 32'h7 : 32'h0);
      check("to_exb", a_exb, (i < 7) ? 32'h1 : 32'h0);
      check("to_pulse", a_to, (i == 7) ? 32'h1 : 32'h0);
      check("to_state", a_state, (i >= 1 && i <= 7) ? 32'h1 : 32'h0);
      step();
      mc_start_a = 1'b0;
    end

    // Done in the would-be timeout cycle wins
    mc_start_a = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i == 7) mc_done_a = 1'b1;
      @(negedge clk);
      check("dw_stall", a_stall, (i < 7) ? 32'h7 : 32'h0);
      check("dw_to", a_to, 0);
      check("dw_state", a_state, (i >= 1 && i <= 7) ? 32'h1 : 32'h0);
      step();
      mc_start_a = 1'b0;
      mc_done_a = 1'b0;
    end

    // Multi-cycle completing after 10 cycles
    mc_start_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 10) mc_done_b = 1'b1;
      @(negedge clk);
      check("mc_stall", b_stall, (i < 10) ? 32'h7 : 32'h0);
      check("mc_exb", b_exb, (i < 10) ? 32'h1 : 32'h0);
      check("mc_state", b_state, (i >= 1 && i <= 10) ? 32'h1 : 32'h0);
      check("mc_to", b_to, 0);
      step();
      mc_start_b = 1'b0;
      mc_done_b = 1'b0;
    end

    // Reset in the middle of MC_WAIT
    mc_start_a = 1'b1;
    step();
    mc_start_a = 1'b0;
    step();
    step();
    check("pre_rst_state", a_state, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_state", a_state, 0);
    check("mid_rst_stall", a_stall, 0);
    check("mid_rst_exb", a_exb, 0);
    check("mid_rst_to", a_to, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_to) saw_to = 1'b1;
      step();
    end
    check("post_rst_no_to", saw_to, 0);
    check("post_rst_state", a_state, 0);

    // Jump with three flush cycles on A, one on B; lu ignored while A flushes
    jump = 1'b1; jump_addr = 32'h0000_0100;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) set_lu();
      @(negedge clk);
      check("j_jump", a_jump, (i == 0) ? 32'h1 : 32'h0);
      check("j_flush", a_flush, (i < 3) ? 32'h1 : 32'h0);
      check("j_jaddr", a_jaddr, 32'h0000_0100);
      check("j_state", a_state, (i == 1 || i == 2) ? 32'h2 : 32'h0);
      check("jb_flush", b_flush, (i == 0) ? 32'h1 : 32'h0);
      check("jb_state", b_state, 0);
      check("jb_jaddr", b_jaddr, 32'h0000_0100);
      if (i == 1) begin
        check("j_lu_ign_stall", a_stall, 0);
        check("j_lu_ign_bubble", a_bubble, 0);
        check("jb_lu_stall", b_stall, 5'b00011);
      end
      step();
      jump = 1'b0; jump_addr = 32'hDEAD_BEEF;
      clear_lu();
    end

    // Jump beats mc_start and load-use in the same cycle
    jump = 1'b1; jump_addr = 32'h0000_0200; mc_start_a = 1'b1;
    set_lu();
    @(negedge clk);
    check("sim_jump", a_jump, 1);
    check("sim_jaddr", a_jaddr, 32'h0000_0200);
    check("sim_bubble", a_bubble, 0);
    check("sim_stall", a_stall, 0);
    check("sim_exb", a_exb, 0);
    step();
    jump = 1'b0; mc_start_a = 1'b0;
    clear_lu();
    @(negedge clk);
    check("sim_state_flush", a_state, 2);
    check("sim_stall2", a_stall, 0);
    step();
    step();
    @(negedge clk);
    check("sim_state_run", a_state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
